// File: rtl/sd_clk_ctrl_pkg.sv
// Shared definitions for the GhostSD clock sequencer: state encodings,
// clock-select constants and a constant-evaluable clog2.
package sd_clk_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_READY  = 3'd2,
        ST_GATE   = 3'd3,
        ST_SWITCH = 3'd4,
        ST_UNGATE = 3'd5
    } state_e;

    localparam logic SEL_SLOW = 1'b0;
    localparam logic SEL_FAST = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_clk_ctrl_timer.sv
// Loadable down-counter that saturates at zero; shared by the power-up
// interval and the gate/switch settle intervals.
module sd_clk_ctrl_timer #(
    parameter int W = 8
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         iload,
    input  logic [W-1:0] iload_val,
    output logic         ozero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (iload) begin
            count_d = iload_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign ozero = (count_q == '0);

endmodule

// File: rtl/sd_clk_ctrl.sv
// SD clock source sequencer: power-up slow clocks, then glitch-safe
// slow/fast switching by gating, reselecting and ungating the clock path.
//
// state  | meaning
// OFF    | clock gated, slow selected, waiting for istart
// PWRUP  | slow clock running for the initial INIT_CYCLES periods
// READY  | clock stable; pending requests evaluated when bus idle
// GATE   | clock gated, old source still selected, settling
// SWITCH | clock gated, new source selected, settling
// UNGATE | clock re-enabled for one cycle before READY
module sd_clk_ctrl
    import sd_clk_ctrl_pkg::*;
#(
    parameter int SLOW_DIV    = 64,
    parameter int INIT_CYCLES = 80,
    parameter int SETTLE      = 16
) (
    input  logic iclk,
    input  logic irst,
    input  logic istart,
    input  logic istop,
    input  logic ireq_fast,
    input  logic ireq_slow,
    input  logic ibusy,
    output logic osel_clk,
    output logic oclk_en,
    output logic oready,
    output logic oinit_done,
    output logic odone
);

    localparam int CNT_W = clog2(INIT_CYCLES * SLOW_DIV);
    localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(INIT_CYCLES * SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   clk_en_q, clk_en_d;
    logic   ready_q, ready_d;
    logic   init_done_q, init_done_d;
    logic   done_q, done_d;
    logic   pend_vld_q, pend_vld_d;
    logic   pend_tgt_q, pend_tgt_d;
    logic   tgt_q, tgt_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    sd_clk_ctrl_timer #(
        .W(CNT_W)
    ) u_timer (
        .iclk      (iclk),
        .irst      (irst),
        .iload     (tmr_load),
        .iload_val (tmr_val),
        .ozero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        clk_en_d    = clk_en_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        done_d      = 1'b0;
        pend_vld_d  = pend_vld_q;
        pend_tgt_d  = pend_tgt_q;
        tgt_d       = tgt_q;
        tmr_load    = 1'b0;
        tmr_val     = SETTLE_LOAD;

        // A request arriving this cycle is visible to READY immediately; slow wins a tie.
        if (state_q != ST_OFF && (ireq_fast || ireq_slow)) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = ireq_slow ? SEL_SLOW : SEL_FAST;
        end

        case (state_q)
            ST_OFF: begin
                sel_d    = SEL_SLOW;
                clk_en_d = 1'b0;
                ready_d  = 1'b0;
                if (istart) begin
                    state_d  = ST_PWRUP;
                    clk_en_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = INIT_LOAD;
                end
            end
            ST_PWRUP: begin
                if (tmr_zero) begin
                    state_d     = ST_READY;
                    ready_d     = 1'b1;
                    init_done_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            ST_READY: begin
                if (pend_vld_d && !ibusy) begin
                    pend_vld_d = 1'b0;
                    if (pend_tgt_d == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_GATE;
                        tgt_d    = pend_tgt_d;
                        ready_d  = 1'b0;
                        clk_en_d = 1'b0;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_GATE: begin
                if (tmr_zero) begin
                    state_d  = ST_SWITCH;
                    sel_d    = tgt_q;
                    tmr_load = 1'b1;
                end
            end
            ST_SWITCH: begin
                if (tmr_zero) begin
                    state_d  = ST_UNGATE;
                    clk_en_d = 1'b1;
                end
            end
            ST_UNGATE: begin
                state_d = ST_READY;
                ready_d = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        if (istop) begin
            state_d     = ST_OFF;
            sel_d       = SEL_SLOW;
            clk_en_d    = 1'b0;
            ready_d     = 1'b0;
            init_done_d = 1'b0;
            done_d      = 1'b0;
            pend_vld_d  = 1'b0;
            pend_tgt_d  = SEL_SLOW;
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q     <= ST_OFF;
            sel_q       <= SEL_SLOW;
            clk_en_q    <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_tgt_q  <= SEL_SLOW;
            tgt_q       <= SEL_SLOW;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            clk_en_q    <= clk_en_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            done_q      <= done_d;
            pend_vld_q  <= pend_vld_d;
            pend_tgt_q  <= pend_tgt_d;
            tgt_q       <= tgt_d;
        end
    end

    assign osel_clk   = sel_q;
    assign oclk_en    = clk_en_q;
    assign oready     = ready_q;
    assign oinit_done = init_done_q;
    assign odone      = done_q;

endmodule
